ex_divider: RTL

Iterative RV32M divide/remainder unit in the EX stage, alongside the ALU. Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. Every trial subtraction goes through a carry-lookahead subtractor built from the ALU's 8-bit CLA slices. The EX stage stalls on `busy` and captures `result` when `valid` pulses.

---
 rtl/ex_pkg.sv | 50 +++++
 rtl/addsub_cla.sv | 34 +++
 rtl/ex_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and helpers for the EX-stage divider.
//   div_op_e    : RV32M divide/remainder operation encodings
//   div_state_e : divider FSM states
//   DIV_CNT_W   : iteration counter width for the default 32-bit datapath
//   cla8()      : one 8-bit carry-lookahead slice, returns {cout, sum}
package ex_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_XLEN);

  // Each carry is the flattened lookahead sum g[i] | p[i]g[i-1] | ... | p[i..0]cin,
  // so no carry depends on the previous slice-internal carry.
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                      input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pr;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = g[i];
      pr  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pr & g[j]);
        pr  = pr & p[j];
      end
      acc      = acc | (pr & cin);
      c[i + 1] = acc;
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage

// File: rtl/addsub_cla.sv
// addsub_cla: XLEN-bit adder/subtractor built from a chain of 8-bit CLA slices.
//   i_x, i_y : operands
//   i_sub    : 1 = i_x - i_y (computed as i_x + ~i_y + 1), 0 = i_x + i_y
//   o_sum    : result, modulo 2^XLEN
//   o_cout   : carry out of the top slice (for subtraction: 1 = no borrow)
module addsub_cla
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_x,
  input  logic [XLEN-1:0] i_y,
  input  logic            i_sub,
  output logic [XLEN-1:0] o_sum,
  output logic            o_cout
);

  localparam int NSLICE = XLEN / 8;

  logic [XLEN-1:0] w_y;
  logic            w_carry;

  assign w_y = i_sub ? ~i_y : i_y;

  always_comb begin
    o_sum   = '0;
    w_carry = i_sub;
    for (int i = 0; i < NSLICE; i++) begin
      {w_carry, o_sum[i*8 +: 8]} = cla8(i_x[i*8 +: 8], w_y[i*8 +: 8], w_carry);
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/ex_divider.sv
// ex_divider: iterative radix-2 restoring divide/remainder unit (DIV, DIVU, REM, REMU).
//   clk, rst : clock, asynchronous active-high reset
//   start    : launch request, sampled only in IDLE
//   flush    : abort; takes priority over start and suppresses valid
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b     : dividend, divisor
//   busy     : high while CALC or DONE (dropped immediately by flush)
//   valid    : one-cycle pulse in DONE, result is final
//   result   : quotient or remainder, held until the next valid
//
// state | meaning
// IDLE  | waiting for start; operand class decoded here
// CALC  | one quotient bit per cycle, counter counts XLEN-1 down to 0
// DONE  | sign correction, result presented with valid
module ex_divider
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state;
  div_op_e         r_op;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [CNT_W-1:0] r_cnt;

  logic            w_is_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_rem_sh;
  logic            w_shout;
  logic            w_take;
  logic [XLEN-1:0] w_t_x;
  logic [XLEN-1:0] w_t_y;
  logic [XLEN-1:0] w_t_sum;
  logic            w_t_cout;
  logic [XLEN-1:0] w_n_y;
  logic [XLEN-1:0] w_n_sum;
  logic            w_n_cout;
  logic            w_is_rem;
  logic [XLEN-1:0] w_fin_sel;
  logic            w_fin_neg;
  logic [XLEN-1:0] w_fin;
  logic            w_done;

  assign w_is_signed = (op == DIV) || (op == REM);
  assign w_a_neg     = w_is_signed & a[XLEN-1];
  assign w_b_neg     = w_is_signed & b[XLEN-1];
  assign w_ovf       = w_is_signed & (a == MIN_NEG) & (b == '1);

  // The bit shifted out of the remainder is the (XLEN+1)th bit of the trial
  // minuend; when set, the subtraction cannot borrow.
  assign w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_shout  = r_rem[XLEN-1];
  assign w_take   = w_shout | w_t_cout;

  // Trial subtractor; in IDLE it produces 0 - a for the dividend magnitude.
  assign w_t_x = (r_state == CALC) ? w_rem_sh : '0;
  assign w_t_y = (r_state == CALC) ? r_div    : a;

  addsub_cla #(.XLEN(XLEN)) u_trial (
    .i_x    (w_t_x),
    .i_y    (w_t_y),
    .i_sub  (1'b1),
    .o_sum  (w_t_sum),
    .o_cout (w_t_cout)
  );

  // Negator: 0 - b in IDLE (its carry out is set only when b is zero),
  // 0 - final value in DONE.
  assign w_is_rem  = (r_op == REM) || (r_op == REMU);
  assign w_fin_sel = w_is_rem ? r_rem   : r_quo;
  assign w_fin_neg = w_is_rem ? r_neg_r : r_neg_q;
  assign w_n_y     = (r_state == DONE) ? w_fin_sel : b;
  assign w_b_zero  = w_n_cout;

  addsub_cla #(.XLEN(XLEN)) u_neg (
    .i_x    ('0),
    .i_y    (w_n_y),
    .i_sub  (1'b1),
    .o_sum  (w_n_sum),
    .o_cout (w_n_cout)
  );

  assign w_fin  = w_fin_neg ? w_n_sum : w_fin_sel;
  assign w_done = (r_state == DONE) & ~flush;

  assign busy   = (r_state != IDLE) & ~flush;
  assign valid  = w_done;
  assign result = w_done ? w_fin : r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= DIV;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!flush && start) begin
            r_op  <= div_op_e'(op);
            r_div <= b;
            if (w_b_zero) begin
              r_quo   <= '1;
              r_rem   <= a;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= DONE;
            end else if (w_ovf) begin
              r_quo   <= MIN_NEG;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= DONE;
            end else begin
              r_quo   <= w_a_neg ? w_t_sum : a;
              r_div   <= w_b_neg ? w_n_sum : b;
              r_rem   <= '0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CNT_W'(XLEN - 1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_take ? w_t_sum : w_rem_sh;
            r_quo <= {r_quo[XLEN-2:0], w_take};
            if (r_cnt == '0) begin
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (!flush) begin
            r_result <= w_fin;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
